// File: rtl/bullet_pool_arbiter_if.sv
// bullet_pool_arbiter_if: fire/slot bus between keycode decode, the bullet
// pool arbiter (slave) and the per-slot bullet movers (master side).
interface bullet_pool_arbiter_if #(
  parameter int NUM_SLOTS = 4
);
  logic [1:0]             fire_req;
  logic [1:0]             dir_p0;
  logic [1:0]             dir_p1;
  logic [NUM_SLOTS-1:0]   slot_kill;
  logic [NUM_SLOTS-1:0]   slot_active;
  logic [NUM_SLOTS-1:0]   slot_owner;
  logic [2*NUM_SLOTS-1:0] slot_dir;
  logic [NUM_SLOTS-1:0]   launch;
  logic [1:0]             grant;
  logic [1:0]             denied;

  modport master (
    output fire_req, dir_p0, dir_p1, slot_kill,
    input  slot_active, slot_owner, slot_dir, launch, grant, denied
  );

  modport slave (
    input  fire_req, dir_p0, dir_p1, slot_kill,
    output slot_active, slot_owner, slot_dir, launch, grant, denied
  );
endinterface

// File: rtl/bullet_pool_arbiter.sv
// bullet_pool_arbiter: shares NUM_SLOTS bullet slots between two players.
// Turns fire presses into launches, enforces a per-player cooldown and
// in-flight cap, and round-robins the last free slot on a tie.
// Optional feature: define BULLET_AUTOFIRE_EN for level-sensitive autofire.
module bullet_pool_arbiter #(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int COOLDOWN       = 8
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  bullet_pool_arbiter_if.slave bus
);

  typedef enum logic {
    RR_P1 = 1'b0,
    RR_P2 = 1'b1
  } rr_t;

  localparam logic [7:0]           CD_LOAD = 8'(COOLDOWN);
  localparam logic [3:0]           CAP     = 4'(MAX_PER_PLAYER);
  localparam logic [NUM_SLOTS-1:0] ONE     = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  // registered state
  logic [7:0]             cd0;
  logic [7:0]             cd1;
  rr_t                    rr;
  logic [NUM_SLOTS-1:0]   slot_active;
  logic [NUM_SLOTS-1:0]   slot_owner;
  logic [2*NUM_SLOTS-1:0] slot_dir;
  logic [NUM_SLOTS-1:0]   launch;
  logic [1:0]             grant;
  logic [1:0]             denied;

  // next-state values
  logic [7:0]             cd0_nxt;
  logic [7:0]             cd1_nxt;
  rr_t                    rr_nxt;
  logic [NUM_SLOTS-1:0]   active_nxt;
  logic [NUM_SLOTS-1:0]   owner_nxt;
  logic [2*NUM_SLOTS-1:0] dir_nxt;
  logic [NUM_SLOTS-1:0]   launch_nxt;
  logic [1:0]             grant_nxt;
  logic [1:0]             denied_nxt;

  // decode
  logic [1:0]             press;
  logic [1:0]             cd_busy;
  logic [1:0]             cap_ok;
  logic [1:0]             elig;
  logic [NUM_SLOTS-1:0]   free;
  logic [NUM_SLOTS-1:0]   live;
  logic [NUM_SLOTS-1:0]   rest;
  logic [NUM_SLOTS-1:0]   first_free;
  logic [NUM_SLOTS-1:0]   second_free;
  logic [NUM_SLOTS-1:0]   alloc0;
  logic [NUM_SLOTS-1:0]   alloc1;
  logic [3:0]             cnt0;
  logic [3:0]             cnt1;
  logic                   have_one;
  logic                   have_two;

`ifdef BULLET_AUTOFIRE_EN
  assign press = bus.fire_req;
`else
  logic [1:0] fire_req_q;

  // Previous button level; resets high so a button held through reset is not a press.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_req_q <= 2'b11;
    end else begin
      fire_req_q <= bus.fire_req;
    end
  end

  assign press = bus.fire_req & ~fire_req_q;
`endif

  // Free/live slot masks, the two lowest free slots and per-player in-flight counts.
  always_comb begin
    free        = ~slot_active | bus.slot_kill;
    live        = slot_active & ~bus.slot_kill;
    first_free  = free & (~free + ONE);
    rest        = free & ~first_free;
    second_free = rest & (~rest + ONE);
    have_one    = |free;
    have_two    = |rest;
    cnt0        = '0;
    cnt1        = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      cnt0 = cnt0 + {3'b000, live[i] & ~slot_owner[i]};
      cnt1 = cnt1 + {3'b000, live[i] & slot_owner[i]};
    end
    cd_busy = {cd1 != 8'd0, cd0 != 8'd0};
    cap_ok  = {cnt1 < CAP, cnt0 < CAP};
    elig    = press & ~cd_busy & cap_ok;
  end

  // Slot allocation; rr only moves when both players fight over a single slot.
  always_comb begin
    alloc0 = '0;
    alloc1 = '0;
    rr_nxt = rr;
    case (elig)
      2'b01: if (have_one) alloc0 = first_free;
      2'b10: if (have_one) alloc1 = first_free;
      2'b11: begin
        if (have_two) begin
          alloc0 = first_free;
          alloc1 = second_free;
        end else if (have_one) begin
          if (rr == RR_P1) begin
            alloc0 = first_free;
            rr_nxt = RR_P2;
          end else begin
            alloc1 = first_free;
            rr_nxt = RR_P1;
          end
        end
      end
      default: ;
    endcase
  end

  // Grant/deny pulses and slot bookkeeping; a launch overrides a same-cycle kill.
  always_comb begin
    launch_nxt = alloc0 | alloc1;
    grant_nxt  = {|alloc1, |alloc0};
`ifdef BULLET_AUTOFIRE_EN
    // a held button waiting out its cooldown is silent, not denied
    denied_nxt = press & ~grant_nxt & ~(cd_busy & cap_ok);
`else
    denied_nxt = press & ~grant_nxt;
`endif
    active_nxt = live | launch_nxt;
    owner_nxt  = slot_owner;
    dir_nxt    = slot_dir;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (alloc0[i]) begin
        owner_nxt[i]       = 1'b0;
        dir_nxt[2*i +: 2]  = bus.dir_p0;
      end
      if (alloc1[i]) begin
        owner_nxt[i]       = 1'b1;
        dir_nxt[2*i +: 2]  = bus.dir_p1;
      end
    end
  end

  // Cooldowns reload on a grant, otherwise count down and stick at zero.
  always_comb begin
    cd0_nxt = cd0;
    cd1_nxt = cd1;
    if (grant_nxt[0]) begin
      cd0_nxt = CD_LOAD;
    end else if (cd_busy[0]) begin
      cd0_nxt = cd0 - 8'd1;
    end
    if (grant_nxt[1]) begin
      cd1_nxt = CD_LOAD;
    end else if (cd_busy[1]) begin
      cd1_nxt = cd1 - 8'd1;
    end
  end

  // State and output registers; reset clears all slots without any pulses.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cd0         <= '0;
      cd1         <= '0;
      rr          <= RR_P1;
      slot_active <= '0;
      slot_owner  <= '0;
      slot_dir    <= '0;
      launch      <= '0;
      grant       <= '0;
      denied      <= '0;
    end else begin
      cd0         <= cd0_nxt;
      cd1         <= cd1_nxt;
      rr          <= rr_nxt;
      slot_active <= active_nxt;
      slot_owner  <= owner_nxt;
      slot_dir    <= dir_nxt;
      launch      <= launch_nxt;
      grant       <= grant_nxt;
      denied      <= denied_nxt;
    end
  end

  assign bus.slot_active = slot_active;
  assign bus.slot_owner  = slot_owner;
  assign bus.slot_dir    = slot_dir;
  assign bus.launch      = launch;
  assign bus.grant       = grant;
  assign bus.denied      = denied;

endmodule
